// File: rtl/uart_program_loader_pkg.sv
// Shared ESFA definitions: instruction geometry, frame codes, loader FSM encoding
// and instruction field offsets used by the downstream executor.
package esfa_pkg;

    localparam int INSTR_WIDTH      = 56;
    localparam int INSTR_WORD_BYTES = 7;

    localparam logic [7:0] SYNC_CODE = 8'hA5;
    localparam logic [7:0] ACK_CODE  = 8'h06;
    localparam logic [7:0] NAK_CODE  = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DATA,
        ST_CHECK,
        ST_REPLY
    } loader_state_e;

    // Instruction word field layout (LSB offsets and widths)
    localparam int FLD_INDEX_LSB    = 8;
    localparam int FLD_VALUE_LSB    = 16;
    localparam int FLD_META_LSB     = 24;
    localparam int FLD_IS_META_BIT  = 32;
    localparam int FLD_SELECTOR_LSB = 40;
    localparam int FLD_ASSERT_BIT   = 48;
    localparam int FLD_BYTE_W       = 8;

    function automatic logic [7:0] instr_field8(input logic [INSTR_WIDTH-1:0] w, input int lsb);
        return w[lsb +: FLD_BYTE_W];
    endfunction

endpackage

// File: rtl/uart_program_loader_if.sv
// Loader-side bundle: UART rx/tx handshake, instruction RAM port B and run-gating status.
interface uart_program_loader_if
    import esfa_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) ();

    logic                   rx_valid;
    logic [7:0]             rx_byte;
    logic                   tx_busy;
    logic                   tx_start;
    logic [7:0]             tx_data;
    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic [INSTR_WIDTH-1:0] mem_din;
    logic [ADDR_WIDTH-1:0]  highest_instruction;
    logic                   program_valid;
    logic                   load_done;
    logic                   load_error;
    logic                   busy;

    modport master (
        input  rx_valid, rx_byte, tx_busy,
        output tx_start, tx_data, mem_we, mem_addr, mem_din,
               highest_instruction, program_valid, load_done, load_error, busy
    );

    modport slave (
        output rx_valid, rx_byte, tx_busy,
        input  tx_start, tx_data, mem_we, mem_addr, mem_din,
               highest_instruction, program_valid, load_done, load_error, busy
    );

endinterface

// File: rtl/uart_program_loader_timeout.sv
// Inter-byte idle watchdog: reloads while cleared or disabled, counts down while
// enabled, and flags expiry on the cycle it would pass zero.
module loader_timeout #(
    parameter int unsigned CYCLES = 12000000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;
    localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i || !en_i) begin
            cnt_q <= LOAD;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // A byte arriving in the expiry cycle wins over the timeout
    assign expire_o = en_i && !clr_i && (cnt_q == '0);

endmodule

// File: rtl/uart_program_loader.sv
// Frame receiver for the ESFA instruction RAM: SYNC, N, N*7 payload bytes, XOR check;
// packs little-endian 56-bit words, writes them out, and replies ACK/NAK.
module uart_program_loader
    import esfa_pkg::*;
#(
    parameter int          WORD_BYTES     = INSTR_WORD_BYTES,
    parameter int          ADDR_WIDTH     = 8,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_CODE,
    parameter logic [7:0]  ACK_BYTE       = ACK_CODE,
    parameter logic [7:0]  NAK_BYTE       = NAK_CODE,
    parameter int unsigned TIMEOUT_CYCLES = 12000000
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_program_loader_if.master  bus
);

    localparam int WW   = 8 * WORD_BYTES;
    localparam int IDXW = $clog2(WORD_BYTES);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORD_BYTES - 1);

    loader_state_e         state_q;
    logic [IDXW-1:0]       idx_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            n_q;
    logic [7:0]            chk_q;
    logic [WW-1:0]         asm_q;

    logic                  tx_start_q;
    logic [7:0]            tx_data_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [WW-1:0]         mem_din_q;
    logic [ADDR_WIDTH-1:0] highest_q;
    logic                  program_valid_q;
    logic                  load_done_q;
    logic                  load_error_q;

    logic                  tmr_en;
    logic                  expire;
    logic [WW-1:0]         asm_next;
    logic [ADDR_WIDTH-1:0] last_addr;

    assign tmr_en    = (state_q == ST_COUNT) || (state_q == ST_DATA) || (state_q == ST_CHECK);
    assign asm_next  = {bus.rx_byte, asm_q[WW-1:8]};
    assign last_addr = ADDR_WIDTH'(n_q) - ADDR_WIDTH'(1);

    loader_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .en_i     (tmr_en),
        .clr_i    (bus.rx_valid),
        .expire_o (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            idx_q           <= '0;
            addr_q          <= '0;
            n_q             <= '0;
            chk_q           <= '0;
            asm_q           <= '0;
            tx_start_q      <= 1'b0;
            tx_data_q       <= '0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_din_q       <= '0;
            highest_q       <= '0;
            program_valid_q <= 1'b0;
            load_done_q     <= 1'b0;
            load_error_q    <= 1'b0;
        end else begin
            mem_we_q    <= 1'b0;
            load_done_q <= 1'b0;
            tx_start_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.rx_valid && bus.rx_byte == SYNC_BYTE) begin
                        state_q         <= ST_COUNT;
                        program_valid_q <= 1'b0;
                        load_error_q    <= 1'b0;
                        idx_q           <= '0;
                        addr_q          <= '0;
                    end
                end
                ST_COUNT: begin
                    if (bus.rx_valid) begin
                        if (bus.rx_byte == 8'd0) begin
                            load_error_q <= 1'b1;
                            tx_data_q    <= NAK_BYTE;
                            state_q      <= ST_REPLY;
                        end else begin
                            n_q     <= bus.rx_byte;
                            chk_q   <= bus.rx_byte;
                            state_q <= ST_DATA;
                        end
                    end else if (expire) begin
                        load_error_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (bus.rx_valid) begin
                        chk_q <= chk_q ^ bus.rx_byte;
                        asm_q <= asm_next;
                        if (idx_q == LAST_IDX) begin
                            mem_we_q   <= 1'b1;
                            mem_addr_q <= addr_q;
                            mem_din_q  <= asm_next;
                            addr_q     <= addr_q + 1'b1;
                            idx_q      <= '0;
                            if (addr_q == last_addr) begin
                                state_q <= ST_CHECK;
                            end
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else if (expire) begin
                        load_error_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (bus.rx_valid) begin
                        state_q <= ST_REPLY;
                        if (bus.rx_byte == chk_q) begin
                            highest_q       <= ADDR_WIDTH'(n_q);
                            program_valid_q <= 1'b1;
                            load_done_q     <= 1'b1;
                            tx_data_q       <= ACK_BYTE;
                        end else begin
                            load_error_q <= 1'b1;
                            tx_data_q    <= NAK_BYTE;
                        end
                    end else if (expire) begin
                        load_error_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                ST_REPLY: begin
                    // Incoming bytes are ignored until the reply has been handed off
                    if (!bus.tx_busy) begin
                        tx_start_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.tx_start            = tx_start_q;
    assign bus.tx_data             = tx_data_q;
    assign bus.mem_we              = mem_we_q;
    assign bus.mem_addr            = mem_addr_q;
    assign bus.mem_din             = mem_din_q;
    assign bus.highest_instruction = highest_q;
    assign bus.program_valid       = program_valid_q;
    assign bus.load_done           = load_done_q;
    assign bus.load_error          = load_error_q;
    assign bus.busy                = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed and randomized frame bench for uart_program_loader against a frame-level model.
module tb_uart_program_loader;

    localparam int TMO = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_program_loader_if #(.ADDR_WIDTH(8)) bus ();

    uart_program_loader #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int checks = 0;
    int errors = 0;

    logic [63:0] wq[$];
    logic [7:0]  txq[$];
    int          done_cnt = 0;
    int          done_pv_bad = 0;
    int          busy_viol = 0;

    logic [7:0] exp_hi = '0;
    logic       exp_valid = 1'b0;
    logic       exp_err = 1'b0;

    always @(negedge clk) begin
        if (bus.mem_we) wq.push_back({bus.mem_addr, bus.mem_din});
        if (bus.tx_start) begin
            txq.push_back(bus.tx_data);
            if (bus.tx_busy) busy_viol++;
        end
        if (bus.load_done) begin
            done_cnt++;
            if (bus.program_valid !== 1'b1) done_pv_bad++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_byte  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_byte  = $urandom_range(0, 255);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic check_status(input string tag);
        check({tag, "_hi"},    bus.highest_instruction, exp_hi);
        check({tag, "_valid"}, bus.program_valid, exp_valid);
        check({tag, "_err"},   bus.load_error, exp_err);
        check({tag, "_busy"},  bus.busy, 1'b0);
    endtask

    // Frame of n words; bad flips the checksum LSB; fixed uses 11,22,..,77 payload
    task automatic run_frame(input string tag, input int n, input bit bad,
                             input int busy_cyc, input bit fixed);
        logic [7:0]  payload[$];
        logic [55:0] wd;
        logic [7:0]  chk;
        logic [7:0]  reply;
        int          nwr;
        wq.delete();
        txq.delete();
        done_cnt = 0;
        done_pv_bad = 0;
        send_byte(8'hA5);
        check({tag, "_sync_err_clr"}, bus.load_error, 1'b0);
        check({tag, "_sync_pv_clr"},  bus.program_valid, 1'b0);
        chk = n[7:0];
        for (int i = 0; i < 7 * n; i++) begin
            payload.push_back(fixed ? 8'((i % 7 + 1) * 8'h11) : 8'($urandom_range(0, 255)));
            chk ^= payload[i];
        end
        if (n == 0) bad = 1'b1;
        if (bad && n != 0) chk ^= 8'h01;
        if (busy_cyc > 0) bus.tx_busy = 1'b1;
        send_byte(n[7:0]);
        if (n != 0) begin
            foreach (payload[i]) send_byte(payload[i]);
            send_byte(chk);
        end
        if (busy_cyc > 0) begin
            repeat (busy_cyc) @(negedge clk);
            check({tag, "_tx_held"}, 64'(txq.size()), 64'd0);
            bus.tx_busy = 1'b0;
        end
        for (int i = 0; i < 50 && txq.size() == 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        reply = bad ? 8'h15 : 8'h06;
        check({tag, "_tx_count"}, 64'(txq.size()), 64'd1);
        check({tag, "_tx_data"}, (txq.size() > 0) ? txq[0] : 8'hxx, reply);
        if (bad) begin
            exp_valid = 1'b0;
            exp_err   = 1'b1;
        end else begin
            exp_hi    = n[7:0];
            exp_valid = 1'b1;
            exp_err   = 1'b0;
        end
        check({tag, "_done_cnt"}, 64'(done_cnt), bad ? 64'd0 : 64'd1);
        check({tag, "_done_pv"}, 64'(done_pv_bad), 64'd0);
        if (n == 0) check({tag, "_no_write"}, 64'(wq.size()), 64'd0);
        if (!bad) begin
            check({tag, "_write_count"}, 64'(wq.size()), 64'(n));
            nwr = (wq.size() < n) ? wq.size() : n;
            for (int w = 0; w < nwr; w++) begin
                wd = '0;
                for (int k = 0; k < 7; k++) wd |= 56'(payload[7 * w + k]) << (8 * k);
                check($sformatf("%s_word%0d", tag, w), wq[w], {8'(w), wd});
            end
        end
        check_status(tag);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_byte  = '0;
        bus.tx_busy  = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_start", bus.tx_start, 1'b0);
        check("rst_tx_data",  bus.tx_data, 8'h00);
        check("rst_mem_we",   bus.mem_we, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 8'h00);
        check("rst_mem_din",  bus.mem_din, 56'h0);
        check("rst_done",     bus.load_done, 1'b0);
        check_status("rst");
        rst = 1'b0;
        @(negedge clk);

        run_frame("good1", 1, 1'b0, 0, 1'b1);
        check("good1_din_const", bus.mem_din, 56'h77665544332211);

        run_frame("good3", 3, 1'b0, 50, 1'b0);
        check("good3_busy_viol", 64'(busy_viol), 64'd0);

        run_frame("badchk", 2, 1'b1, 0, 1'b0);
        run_frame("nzero", 0, 1'b1, 0, 1'b0);

        // Stall mid-word until the idle watchdog fires
        wq.delete();
        txq.delete();
        send_byte(8'hA5);
        send_byte(8'h02);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)));
        repeat (TMO + 50) @(negedge clk);
        exp_valid = 1'b0;
        exp_err   = 1'b1;
        check("tmo_no_tx", 64'(txq.size()), 64'd0);
        check("tmo_no_write", 64'(wq.size()), 64'd0);
        check_status("tmo");
        run_frame("after_tmo", 4, 1'b0, 0, 1'b0);

        // Reset in the middle of DATA, after the first word was written
        wq.delete();
        send_byte(8'hA5);
        send_byte(8'h02);
        for (int i = 0; i < 7; i++) send_byte(8'($urandom_range(0, 255)));
        @(negedge clk);
        check("rstmid_word0", 64'(wq.size()), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_hi = '0;
        exp_valid = 1'b0;
        exp_err = 1'b0;
        check("rstmid_mem_we",   bus.mem_we, 1'b0);
        check("rstmid_mem_addr", bus.mem_addr, 8'h00);
        check("rstmid_mem_din",  bus.mem_din, 56'h0);
        check("rstmid_tx_data",  bus.tx_data, 8'h00);
        check_status("rstmid");
        wq.delete();
        send_byte(8'h33);
        check("stray_busy", bus.busy, 1'b0);
        check("stray_no_write", 64'(wq.size()), 64'd0);
        run_frame("after_rst", 5, 1'b0, 0, 1'b0);

        for (int r = 0; r < 5; r++) begin
            run_frame($sformatf("rand%0d", r), $urandom_range(1, 20),
                      ($urandom_range(0, 3) == 0), $urandom_range(0, 1) * $urandom_range(1, 10), 1'b0);
        end
        run_frame("max_n", 255, 1'b0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
